// File: rtl/async_fifo_flagged.sv
// Dual-clock FIFO with Gray-pointer synchronisers, per-domain fill levels,
// almost-full/almost-empty flags and a registered read port.
// Optional sticky overflow/underflow outputs: define ASYNC_FIFO_ERR_FLAGS_EN.
module async_fifo_flagged #(
  parameter int unsigned DATA        = 8,
  parameter int unsigned ADDR        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 1,
  parameter int unsigned AE_THRESH   = 1
) (
  input  logic            wclk,
  input  logic            wrst,
  input  logic            rclk,
  input  logic            rrst,
  input  logic            w_en,
  input  logic [DATA-1:0] wdata,
  output logic            full,
  output logic            almost_full,
  output logic [ADDR:0]   wr_level,
  input  logic            r_en,
  output logic [DATA-1:0] rdata,
  output logic            rvalid,
  output logic            empty,
  output logic            almost_empty,
  output logic [ADDR:0]   rd_level
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic            overflow,
  output logic            underflow
`endif
);

  localparam int unsigned PW       = ADDR + 1;
  localparam int unsigned DEPTH    = 1 << ADDR;
  localparam int unsigned AF_LEVEL = DEPTH - AF_THRESH;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    for (int i = 0; i < int'(PW); i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [DATA-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin, wgray;
  logic [PW-1:0] rq_pipe [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic          wr_accept_c;
  logic [PW-1:0] wbin_next_c, wgray_next_c, wr_level_next_c;
  logic          full_next_c;

  assign rq = rq_pipe[SYNC_STAGES-1];

  always_comb begin
    wr_accept_c     = w_en && !full;
    wbin_next_c     = wbin + PW'(wr_accept_c);
    wgray_next_c    = bin2gray(wbin_next_c);
    wr_level_next_c = wbin_next_c - gray2bin(rq);
    full_next_c     = (wgray_next_c == {~rq[ADDR:ADDR-1], rq[ADDR-2:0]});
  end

  // Read Gray pointer into wclk domain
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) rq_pipe[i] <= '0;
    end else begin
      rq_pipe[0] <= rgray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) rq_pipe[i] <= rq_pipe[i-1];
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin        <= '0;
      wgray       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      wbin        <= wbin_next_c;
      wgray       <= wgray_next_c;
      full        <= full_next_c;
      almost_full <= (wr_level_next_c >= PW'(AF_LEVEL));
      wr_level    <= wr_level_next_c;
    end
  end

  // Storage is intentionally left unreset
  always_ff @(posedge wclk) begin
    if (wr_accept_c) mem[wbin[ADDR-1:0]] <= wdata;
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] rbin, rgray;
  logic [PW-1:0] wq_pipe [SYNC_STAGES];
  logic [PW-1:0] wq;
  logic          rd_accept_c;
  logic [PW-1:0] rbin_next_c, rgray_next_c, rd_level_next_c;

  assign wq = wq_pipe[SYNC_STAGES-1];

  always_comb begin
    rd_accept_c     = r_en && !empty;
    rbin_next_c     = rbin + PW'(rd_accept_c);
    rgray_next_c    = bin2gray(rbin_next_c);
    rd_level_next_c = gray2bin(wq) - rbin_next_c;
  end

  // Write Gray pointer into rclk domain
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) wq_pipe[i] <= '0;
    end else begin
      wq_pipe[0] <= wgray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) wq_pipe[i] <= wq_pipe[i-1];
    end
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      rbin         <= '0;
      rgray        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      rvalid       <= 1'b0;
      rdata        <= '0;
    end else begin
      rbin         <= rbin_next_c;
      rgray        <= rgray_next_c;
      empty        <= (rgray_next_c == wq);
      almost_empty <= (rd_level_next_c <= PW'(AE_THRESH));
      rd_level     <= rd_level_next_c;
      rvalid       <= rd_accept_c;
      if (rd_accept_c) rdata <= mem[rbin[ADDR-1:0]];
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  // Sticky request-while-blocked indicators, cleared only by their own reset
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst)             overflow <= 1'b0;
    else if (w_en && full) overflow <= 1'b1;
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst)              underflow <= 1'b0;
    else if (r_en && empty) underflow <= 1'b1;
  end
`else
  // Rejected requests are dropped without any indication.
`endif

endmodule

// File: tb/tb_async_fifo_flagged.sv
// Self-checking bench for async_fifo_flagged: directed fill/drain, latency,
// randomized streaming against a queue scoreboard, optional error flags.
module tb_async_fifo_flagged;

  localparam int DATA   = 8;
  localparam int ADDR   = 3;
  localparam int DEPTH  = 8;
  localparam int NWORDS = 100;

  logic            wclk, rclk, wrst, rrst;
  logic            w_en, r_en;
  logic [DATA-1:0] wdata, rdata;
  logic            full, almost_full, empty, almost_empty, rvalid;
  logic [ADDR:0]   wr_level, rd_level;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic            overflow, underflow;
`endif

  async_fifo_flagged #(
    .DATA(DATA), .ADDR(ADDR), .SYNC_STAGES(2), .AF_THRESH(1), .AE_THRESH(1)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .rclk         (rclk),
    .rrst         (rrst),
    .w_en         (w_en),
    .wdata        (wdata),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .r_en         (r_en),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  int checks;
  int failures;
  logic [DATA-1:0] model_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // wclk posedges land on odd ns, rclk posedges on even ns: never coincident
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    rclk = 1'b0;
    #2;
    forever begin
      rclk = 1'b1;
      #7;
      rclk = 1'b0;
      #7;
    end
  end

  initial begin : main
    int unsigned wduty, rduty;
    int          sent, got, wcyc, rcyc;
    logic        pend;
    logic [DATA-1:0] exp_word;

    checks = 0;
    failures = 0;
    wrst = 1'b0; rrst = 1'b0;
    w_en = 1'b0; r_en = 1'b0; wdata = '0;
    #40;

    // Reset state
    check("rst_full",         32'(full),         32'(0));
    check("rst_almost_full",  32'(almost_full),  32'(0));
    check("rst_wr_level",     32'(wr_level),     32'(0));
    check("rst_empty",        32'(empty),        32'(1));
    check("rst_almost_empty", 32'(almost_empty), 32'(1));
    check("rst_rd_level",     32'(rd_level),     32'(0));
    check("rst_rvalid",       32'(rvalid),       32'(0));
    check("rst_rdata",        32'(rdata),        32'(0));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("rst_overflow",     32'(overflow),     32'(0));
    check("rst_underflow",    32'(underflow),    32'(0));
`endif
    @(negedge wclk); wrst = 1'b1;
    @(negedge rclk); rrst = 1'b1;
    repeat (4) @(negedge wclk);

    // Fill with 0x01..0x08, no reads
    for (int i = 1; i <= DEPTH; i++) begin
      w_en = 1'b1;
      wdata = 8'(i);
      @(negedge wclk);
      check("fill_wr_level",    32'(wr_level),    32'(i));
      check("fill_almost_full", 32'(almost_full), 32'(i >= DEPTH - 1));
      check("fill_full",        32'(full),        32'(i == DEPTH));
    end
    wdata = 8'hFF;
    @(negedge wclk);
    w_en = 1'b0;
    check("drop_wr_level", 32'(wr_level), 32'(DEPTH));
    check("drop_full",     32'(full),     32'(1));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("overflow_set",  32'(overflow), 32'(1));
`endif
    repeat (6) @(negedge rclk);
    check("fill_rd_level",     32'(rd_level),     32'(DEPTH));
    check("fill_empty",        32'(empty),        32'(0));
    check("fill_almost_empty", 32'(almost_empty), 32'(0));

    // Drain: words must come back in order, 0xFF never stored
    for (int k = 1; k <= DEPTH; k++) begin
      r_en = 1'b1;
      @(negedge rclk);
      check("drain_rvalid",       32'(rvalid),       32'(1));
      check("drain_rdata",        32'(rdata),        32'(k));
      check("drain_rd_level",     32'(rd_level),     32'(DEPTH - k));
      check("drain_empty",        32'(empty),        32'(k == DEPTH));
      check("drain_almost_empty", 32'(almost_empty), 32'(DEPTH - k <= 1));
    end
    @(negedge rclk);
    r_en = 1'b0;
    check("extra_rd_rvalid", 32'(rvalid), 32'(0));
    check("extra_rd_rdata",  32'(rdata),  32'(DEPTH));
    check("extra_rd_empty",  32'(empty),  32'(1));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("underflow_set",   32'(underflow), 32'(1));
`endif
    repeat (6) @(negedge wclk);
    check("drain_full",        32'(full),        32'(0));
    check("drain_almost_full", 32'(almost_full), 32'(0));
    check("drain_wr_level",    32'(wr_level),    32'(0));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("overflow_sticky",   32'(overflow),    32'(1));
`endif

    // Write-to-empty latency: empty falls on the 3rd rclk edge after the write edge
    @(negedge wclk);
    w_en = 1'b1;
    wdata = 8'hA5;
    @(posedge wclk);
    fork
      begin
        @(negedge wclk);
        w_en = 1'b0;
      end
    join_none
    for (int n = 1; n <= 3; n++) begin
      @(posedge rclk);
      #1;
      check($sformatf("lat_empty_edge%0d", n), 32'(empty), 32'(n < 3));
    end
    @(negedge rclk);
    r_en = 1'b1;
    @(negedge rclk);
    r_en = 1'b0;
    check("lat_rvalid", 32'(rvalid), 32'(1));
    check("lat_rdata",  32'(rdata),  32'(8'hA5));
    repeat (4) @(negedge rclk);
    check("lat_empty_after", 32'(empty),    32'(1));
    check("lat_rd_level",    32'(rd_level), 32'(0));

    // Randomized concurrent streaming against a queue scoreboard
    model_q.delete();
    fork
      begin : writer
        sent = 0;
        wcyc = 0;
        while (sent < NWORDS && wcyc < 5000) begin
          @(negedge wclk);
          wcyc++;
          wduty = (sent < NWORDS / 2) ? 90 : 40;
          w_en  = ($urandom_range(0, 99) < wduty);
          wdata = 8'($urandom);
          if (w_en && !full) begin
            check("stream_wr_room", 32'(model_q.size() < DEPTH), 32'(1));
            model_q.push_back(wdata);
            sent++;
          end
        end
        @(negedge wclk);
        w_en = 1'b0;
        check("stream_sent", 32'(sent), 32'(NWORDS));
      end
      begin : reader
        got  = 0;
        rcyc = 0;
        pend = 1'b0;
        exp_word = '0;
        while (got < NWORDS && rcyc < 8000) begin
          @(negedge rclk);
          rcyc++;
          if (pend) begin
            check("stream_rvalid", 32'(rvalid), 32'(1));
            check("stream_rdata",  32'(rdata),  32'(exp_word));
            got++;
          end else begin
            check("stream_rvalid_idle", 32'(rvalid), 32'(0));
          end
          rduty = (got < NWORDS / 2) ? 30 : 90;
          r_en  = (got < NWORDS) && ($urandom_range(0, 99) < rduty);
          pend  = 1'b0;
          if (r_en && !empty) begin
            check("stream_rd_avail", 32'(model_q.size() != 0), 32'(1));
            if (model_q.size() != 0) exp_word = model_q.pop_front();
            pend = 1'b1;
          end
        end
        r_en = 1'b0;
        check("stream_got", 32'(got), 32'(NWORDS));
      end
    join
    repeat (8) @(negedge rclk);
    repeat (8) @(negedge wclk);
    check("stream_model_left",  32'(model_q.size()), 32'(0));
    check("stream_empty",       32'(empty),          32'(1));
    check("stream_almost_empty",32'(almost_empty),   32'(1));
    check("stream_rd_level",    32'(rd_level),       32'(0));
    check("stream_wr_level",    32'(wr_level),       32'(0));
    check("stream_full",        32'(full),           32'(0));

    // Both resets clear everything, including the sticky flags
    wrst = 1'b0;
    rrst = 1'b0;
    #30;
    check("rst2_empty",  32'(empty),  32'(1));
    check("rst2_rdata",  32'(rdata),  32'(0));
    check("rst2_rvalid", 32'(rvalid), 32'(0));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("rst2_overflow",  32'(overflow),  32'(0));
    check("rst2_underflow", 32'(underflow), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
